// File: rtl/btb_update_ctrl_pkg.sv
// Shared types and constants for the BTB update controller.
// Contents:
//   - datapath widths and default queue/starvation parameters
//   - controller FSM state encoding
//   - btb_upd_req_t: one queued BTB write (delete flag, pc, word-aligned target)
//   - btb_idx(): BTB index extraction from a PC
package btb_update_ctrl_pkg;

    localparam int XLEN           = 32;
    localparam int OFFSET         = 2;
    localparam int BTB_BITS       = 4;
    localparam int QDEPTH_DEF     = 4;
    localparam int STARVE_MAX_DEF = 3;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } ctrl_state_e;

    // Targets are instruction aligned, so the low OFFSET bits are not stored.
    typedef struct packed {
        logic                     del;
        logic [XLEN-1:0]          pc;
        logic [XLEN-OFFSET-1:0]   target;
    } btb_upd_req_t;

    function automatic logic [BTB_BITS-1:0] btb_idx(input logic [XLEN-1:0] pc);
        return pc[BTB_BITS+OFFSET-1:OFFSET];
    endfunction

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Requester-side bus of the BTB update controller.
// Carries the branch-unit update request and the commit-stage delete
// request together with their combinational accept strobes.
//   master : requester side (drives valid/pc/target, observes ready)
//   slave  : controller side
interface btb_update_ctrl_if;
    import btb_update_ctrl_pkg::*;

    logic            upd_valid;
    logic            upd_ready;
    logic [XLEN-1:0] upd_pc;
    logic [XLEN-1:0] upd_target;
    logic            del_valid;
    logic            del_ready;
    logic [XLEN-1:0] del_pc;

    modport master (
        output upd_valid, upd_pc, upd_target, del_valid, del_pc,
        input  upd_ready, del_ready
    );

    modport slave (
        input  upd_valid, upd_pc, upd_target, del_valid, del_pc,
        output upd_ready, del_ready
    );

endinterface

// File: rtl/btb_upd_arbiter.sv
// Two-way fixed-priority arbiter between update and delete requests.
// Delete normally wins; after STARVE_MAX consecutive update losses the
// update is forced to win once. The grant is only a selection: the parent
// reports through accept_i whether the selected request was really taken.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   en_i                arbitration enabled this cycle
//   clear_i             clear the starvation counter (flush)
//   accept_i            selected request was accepted by the queue
//   upd_valid_i/req_i   update request
//   del_valid_i/req_i   delete request
//   grant_upd_o/del_o   selected requester
//   win_req_o           selected request payload
module btb_upd_arbiter
    import btb_update_ctrl_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clear_i,
    input  logic         accept_i,
    input  logic         upd_valid_i,
    input  btb_upd_req_t upd_req_i,
    input  logic         del_valid_i,
    input  btb_upd_req_t del_req_i,
    output logic         grant_upd_o,
    output logic         grant_del_o,
    output btb_upd_req_t win_req_o
);

    localparam int              CW    = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]   MAX_C = CW'(STARVE_MAX);

    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;
    logic          starved_s;

    assign starved_s = (starve_q == MAX_C);

    // Grant selection and winning payload.
    always_comb begin
        grant_upd_o = 1'b0;
        grant_del_o = 1'b0;
        win_req_o   = '0;
        if (en_i && upd_valid_i && (!del_valid_i || starved_s)) begin
            grant_upd_o = 1'b1;
            win_req_o   = upd_req_i;
        end else if (en_i && del_valid_i) begin
            grant_del_o = 1'b1;
            win_req_o   = del_req_i;
        end else begin
            win_req_o   = '0;
        end
    end

    // Starvation counter next state: any cycle a valid update is not taken counts as a loss.
    always_comb begin
        starve_d = starve_q;
        if (clear_i) begin
            starve_d = '0;
        end else if (grant_upd_o && accept_i) begin
            starve_d = '0;
        end else if (en_i && upd_valid_i && !starved_s) begin
            starve_d = starve_q + CW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: arbitrates branch-unit updates and commit-time
// deletes onto the single BTB write port through a small coalescing FIFO,
// and sequences BTB flushes.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        front-end flush request (pulse)
//   hold_i         stall draining; accepts continue
//   req_if         update/delete requester bus (slave side)
//   btb_valid_o    BTB write strobe
//   btb_del_o      write is an invalidation
//   btb_pc_o       write PC
//   btb_target_o   write target (0 for deletes)
//   btb_flush_o    BTB flush strobe
//   busy_o         queue non-empty
module btb_update_ctrl
    import btb_update_ctrl_pkg::*;
#(
    parameter int QDEPTH     = QDEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             hold_i,
    btb_update_ctrl_if.slave req_if,
    output logic             btb_valid_o,
    output logic             btb_del_o,
    output logic [XLEN-1:0]  btb_pc_o,
    output logic [XLEN-1:0]  btb_target_o,
    output logic             btb_flush_o,
    output logic             busy_o
);

    localparam int               PTR_W   = $clog2(QDEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    ctrl_state_e      state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    btb_upd_req_t     mem_q [QDEPTH];

    btb_upd_req_t     upd_req_s, del_req_s, win_req_s, head_req_s;
    logic             grant_upd_s, grant_del_s;
    logic             accept_en_s, drain_s, match_s, accept_s, push_s;
    logic [PTR_W-1:0] match_ptr_s, wr_ptr_s;

    // Requests are only considered in RUN outside a flush request cycle.
    assign accept_en_s = (state_q == ST_RUN) && !flush_i;
    assign drain_s     = accept_en_s && (count_q != '0) && !hold_i;
    assign head_req_s  = mem_q[head_q];

    // Pack the two request sources into queue entries.
    always_comb begin
        upd_req_s        = '0;
        upd_req_s.del    = 1'b0;
        upd_req_s.pc     = req_if.upd_pc;
        upd_req_s.target = req_if.upd_target[XLEN-1:OFFSET];
        del_req_s        = '0;
        del_req_s.del    = 1'b1;
        del_req_s.pc     = req_if.del_pc;
        del_req_s.target = '0;
    end

    btb_upd_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (accept_en_s),
        .clear_i     (state_q == ST_FLUSH),
        .accept_i    (accept_s),
        .upd_valid_i (req_if.upd_valid),
        .upd_req_i   (upd_req_s),
        .del_valid_i (req_if.del_valid),
        .del_req_i   (del_req_s),
        .grant_upd_o (grant_upd_s),
        .grant_del_o (grant_del_s),
        .win_req_o   (win_req_s)
    );

    // Index CAM over occupied slots; the head leaving this cycle cannot absorb a new request.
    always_comb begin
        logic [PTR_W-1:0] rel;
        match_s     = 1'b0;
        match_ptr_s = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            rel = PTR_W'(i) - head_q;
            if (({1'b0, rel} < count_q) && !(drain_s && (PTR_W'(i) == head_q)) &&
                (btb_idx(mem_q[i].pc) == btb_idx(win_req_s.pc))) begin
                match_s     = 1'b1;
                match_ptr_s = PTR_W'(i);
            end else begin
                match_s     = match_s;
            end
        end
    end

    // A coalescing winner never needs a slot, so it is taken even when full.
    assign accept_s         = (grant_upd_s || grant_del_s) && (match_s || (count_q < DEPTH_C));
    assign push_s           = accept_s && !match_s;
    assign wr_ptr_s         = match_s ? match_ptr_s : tail_q;
    assign req_if.upd_ready = grant_upd_s && accept_s;
    assign req_if.del_ready = grant_del_s && accept_s;

    // FSM and queue pointer next state; a flush request held in FLUSH keeps it there.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (state_q)
            ST_RUN: begin
                state_d = flush_i ? ST_FLUSH : ST_RUN;
                head_d  = head_q + PTR_W'(drain_s);
                tail_d  = tail_q + PTR_W'(push_s);
                count_d = count_q + CNT_W'(push_s) - CNT_W'(drain_s);
            end
            ST_FLUSH: begin
                state_d = flush_i ? ST_FLUSH : ST_RUN;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
            default: begin
                state_d = ST_RUN;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
        endcase
    end

    // State and pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue storage: append at tail or overwrite the matching entry in place.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept_s) begin
            mem_q[wr_ptr_s] <= win_req_s;
        end else begin
            mem_q[wr_ptr_s] <= mem_q[wr_ptr_s];
        end
    end

    // BTB write port driven from the head entry; fields are zero when idle.
    always_comb begin
        btb_valid_o  = drain_s;
        btb_del_o    = 1'b0;
        btb_pc_o     = '0;
        btb_target_o = '0;
        if (drain_s) begin
            btb_del_o    = head_req_s.del;
            btb_pc_o     = head_req_s.pc;
            btb_target_o = {head_req_s.target, {OFFSET{1'b0}}};
        end else begin
            btb_del_o    = 1'b0;
        end
    end

    assign btb_flush_o = (state_q == ST_FLUSH);
    assign busy_o      = (count_q != '0);

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: directed stimulus pushes expected
// BTB writes into a queue, a negedge monitor pops and compares every write.
module tb_btb_update_ctrl;

    typedef struct {
        logic        del;
        logic [31:0] pc;
        logic [31:0] tgt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, hold_i;
    logic        btb_valid_o, btb_del_o, btb_flush_o, busy_o;
    logic [31:0] btb_pc_o, btb_target_o;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    btb_update_ctrl_if bus ();

    btb_update_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .hold_i       (hold_i),
        .req_if       (bus),
        .btb_valid_o  (btb_valid_o),
        .btb_del_o    (btb_del_o),
        .btb_pc_o     (btb_pc_o),
        .btb_target_o (btb_target_o),
        .btb_flush_o  (btb_flush_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic exp_push(input logic del, input logic [31:0] pc, input logic [31:0] tgt);
        exp_t e;
        e.del = del;
        e.pc  = pc;
        e.tgt = tgt;
        exp_q.push_back(e);
    endtask

    // Monitor: every BTB write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst_i && btb_valid_o) begin
            exp_t e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got del=%0b pc=%h tgt=%h expected no write",
                         btb_del_o, btb_pc_o, btb_target_o);
            end else begin
                e = exp_q.pop_front();
                if (btb_del_o !== e.del || btb_pc_o !== e.pc || btb_target_o !== e.tgt) begin
                    n_err++;
                    $display("FAIL btb_write: got del=%0b pc=%h tgt=%h expected del=%0b pc=%h tgt=%h",
                             btb_del_o, btb_pc_o, btb_target_o, e.del, e.pc, e.tgt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i         = 1'b1;
        flush_i       = 1'b0;
        hold_i        = 1'b0;
        bus.upd_valid = 1'b0;
        bus.upd_pc    = 32'h0;
        bus.upd_target= 32'h0;
        bus.del_valid = 1'b0;
        bus.del_pc    = 32'h0;
        repeat (2) step();
        rst_i = 1'b0;

        // Reset / idle
        mid();
        chk("rst_valid", {31'h0, btb_valid_o}, 32'h0);
        chk("rst_del",   {31'h0, btb_del_o},   32'h0);
        chk("rst_pc",    btb_pc_o,             32'h0);
        chk("rst_tgt",   btb_target_o,         32'h0);
        chk("rst_flush", {31'h0, btb_flush_o}, 32'h0);
        chk("rst_busy",  {31'h0, busy_o},      32'h0);
        chk("rst_uready",{31'h0, bus.upd_ready}, 32'h0);

        // Single update, one-cycle latency
        step();
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h1000; bus.upd_target = 32'h2000;
        mid();
        chk("idle_upd_ready", {31'h0, bus.upd_ready}, 32'h1);
        exp_push(1'b0, 32'h1000, 32'h2000);
        step();
        bus.upd_valid = 1'b0;
        mid();
        chk("upd_latency_valid", {31'h0, btb_valid_o}, 32'h1);
        chk("upd_latency_busy",  {31'h0, busy_o},      32'h1);
        step();
        mid();
        chk("upd_drained_busy", {31'h0, busy_o}, 32'h0);

        // Single delete
        step();
        bus.del_valid = 1'b1; bus.del_pc = 32'h3000;
        mid();
        chk("idle_del_ready", {31'h0, bus.del_ready}, 32'h1);
        exp_push(1'b1, 32'h3000, 32'h0);
        step();
        bus.del_valid = 1'b0;
        repeat (3) step();

        // Coalesce under hold: update then delete of the same pc leaves one delete
        hold_i = 1'b1;
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h1004; bus.upd_target = 32'h5000;
        mid();
        chk("coal_upd_ready", {31'h0, bus.upd_ready}, 32'h1);
        step();
        bus.upd_valid = 1'b0;
        bus.del_valid = 1'b1; bus.del_pc = 32'h1004;
        mid();
        chk("coal_del_ready", {31'h0, bus.del_ready}, 32'h1);
        chk("coal_hold_nowrite", {31'h0, btb_valid_o}, 32'h0);
        exp_push(1'b1, 32'h1004, 32'h0);
        step();
        bus.del_valid = 1'b0;
        hold_i = 1'b0;
        step();
        mid();
        chk("coal_single_entry_busy", {31'h0, busy_o}, 32'h0);
        repeat (2) step();

        // Starvation: deletes win three times, update forced on the fourth
        bus.del_valid = 1'b1; bus.del_pc = 32'h2000;
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h2010; bus.upd_target = 32'h7000;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk($sformatf("starve_upd_ready_%0d", k), {31'h0, bus.upd_ready}, (k == 3) ? 32'h1 : 32'h0);
            chk($sformatf("starve_del_ready_%0d", k), {31'h0, bus.del_ready}, (k == 3) ? 32'h0 : 32'h1);
            if (k == 3) exp_push(1'b0, 32'h2010, 32'h7000);
            else        exp_push(1'b1, 32'h2000, 32'h0);
            step();
        end
        bus.del_valid = 1'b0;
        bus.upd_valid = 1'b0;
        repeat (4) step();

        // Full queue under hold
        hold_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.upd_valid  = 1'b1;
            bus.upd_pc     = 32'h4000 + 32'(4 * i);
            bus.upd_target = 32'h8000 + 32'(256 * i);
            mid();
            chk($sformatf("fill_ready_%0d", i), {31'h0, bus.upd_ready}, 32'h1);
            exp_push(1'b0, bus.upd_pc, bus.upd_target);
            step();
        end
        bus.upd_pc = 32'h4010; bus.upd_target = 32'hA000;
        mid();
        chk("full_new_idx_ready", {31'h0, bus.upd_ready}, 32'h0);
        step();
        bus.upd_pc = 32'h4004; bus.upd_target = 32'h9990;
        mid();
        chk("full_coalesce_ready", {31'h0, bus.upd_ready}, 32'h1);
        exp_q[1].tgt = 32'h9990;
        step();
        hold_i = 1'b0;
        bus.upd_pc = 32'h4010; bus.upd_target = 32'hA000;
        mid();
        chk("full_drain_same_cycle_ready", {31'h0, bus.upd_ready}, 32'h0);
        step();
        mid();
        chk("full_slot_next_cycle_ready", {31'h0, bus.upd_ready}, 32'h1);
        exp_push(1'b0, 32'h4010, 32'hA000);
        step();
        bus.upd_valid = 1'b0;
        repeat (6) step();

        // Flush discards queued entries
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.upd_valid  = 1'b1;
            bus.upd_pc     = 32'h5000 + 32'(4 * i);
            bus.upd_target = 32'h6000;
            mid();
            chk($sformatf("fl_fill_ready_%0d", i), {31'h0, bus.upd_ready}, 32'h1);
            step();
        end
        hold_i = 1'b0;
        flush_i = 1'b1;
        bus.upd_pc = 32'h500C; bus.upd_target = 32'hB000;
        mid();
        chk("flush_req_ready",   {31'h0, bus.upd_ready}, 32'h0);
        chk("flush_req_nowrite", {31'h0, btb_valid_o},   32'h0);
        chk("flush_req_flush_o", {31'h0, btb_flush_o},   32'h0);
        step();
        flush_i = 1'b0;
        mid();
        chk("flush_state_flush_o", {31'h0, btb_flush_o},   32'h1);
        chk("flush_state_ready",   {31'h0, bus.upd_ready}, 32'h0);
        chk("flush_state_nowrite", {31'h0, btb_valid_o},   32'h0);
        step();
        mid();
        chk("flush_after_busy",    {31'h0, busy_o},        32'h0);
        chk("flush_after_flush_o", {31'h0, btb_flush_o},   32'h0);
        chk("flush_after_ready",   {31'h0, bus.upd_ready}, 32'h1);
        exp_push(1'b0, 32'h500C, 32'hB000);
        step();
        bus.upd_valid = 1'b0;
        repeat (4) step();

        // Flush held across FLUSH extends it by one cycle
        flush_i = 1'b1;
        step();
        mid();
        chk("flush_ext_1", {31'h0, btb_flush_o}, 32'h1);
        step();
        flush_i = 1'b0;
        mid();
        chk("flush_ext_2", {31'h0, btb_flush_o}, 32'h1);
        step();
        mid();
        chk("flush_ext_end", {31'h0, btb_flush_o}, 32'h0);
        repeat (2) step();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
